// File: rtl/scan_chain_driver_if.sv
// ---------------------------------------------------------------------------
// scan_chain_driver_if
//
// Purpose: bundles the two byte streams of the scan chain driver.
//   Write stream (host -> driver): wr_valid, wr_data[7:0] / wr_ready
//   Read stream  (driver -> host): rd_valid, rd_data[7:0] / rd_ready
//
// Modports:
//   master - the host side: drives the write stream, consumes the read stream
//   slave  - the driver side: consumes the write stream, drives the read stream
// ---------------------------------------------------------------------------
interface scan_chain_driver_if;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       rd_ready;

  modport master (
    output wr_valid, wr_data, rd_ready,
    input  wr_ready, rd_valid, rd_data
  );

  modport slave (
    input  wr_valid, wr_data, rd_ready,
    output wr_ready, rd_valid, rd_data
  );
endinterface

// File: rtl/scan_chain_driver.sv
// ---------------------------------------------------------------------------
// scan_chain_driver
//
// Purpose: shifts a full CHAIN_LEN-bit scan chain of a microcontroller. Bits
// to shift in arrive as bytes on the write stream (LSB first), the bits that
// fall out of the chain tail are packed into bytes on the read stream. The
// processor is held stopped (proc_en low) from one quiesce cycle before the
// first shift until the operation completes.
//
// Parameters:
//   CHAIN_LEN - scan chain length in bits (1..4096)
//   CNT_W     - bit counter width, 2**CNT_W must exceed CHAIN_LEN
//
// Ports:
//   clk           - sole clock, rising edge
//   rst_n         - asynchronous active-low reset
//   start_i       - one-cycle request to start a full-chain shift (IDLE only)
//   run_req_i     - software request to let the processor run while idle
//   scan_out_i    - serial data from the chain tail
//   proc_en_o     - processor enable to the microcontroller
//   scan_enable_o - scan shift enable to the microcontroller
//   scan_in_o     - serial data into the chain head
//   busy_o        - high in every state except IDLE
//   done_o        - one-cycle pulse when an operation completes
//   bus           - write/read byte streams (slave side)
// ---------------------------------------------------------------------------
module scan_chain_driver #(
  parameter int CHAIN_LEN = 64,
  parameter int CNT_W     = 13
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic                run_req_i,
  input  logic                scan_out_i,
  output logic                proc_en_o,
  output logic                scan_enable_o,
  output logic                scan_in_o,
  output logic                busy_o,
  output logic                done_o,
  scan_chain_driver_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE,
    QUIESCE,
    SHIFT,
    FLUSH,
    DONE
  } state_e;

  localparam logic [CNT_W-1:0] LastBitIdx = CNT_W'(CHAIN_LEN - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] bitCnt_q, bitCnt_d;
  logic [2:0]       bitIdx_q, bitIdx_d;
  logic [7:0]       wrBuf_q, wrBuf_d;
  logic             wrBufValid_q, wrBufValid_d;
  logic [7:0]       actByte_q, actByte_d;
  logic             actValid_q, actValid_d;
  logic [7:0]       capByte_q, capByte_d;
  logic             capHeld_q, capHeld_d;
  logic [7:0]       outData_q, outData_d;
  logic             outValid_q, outValid_d;
  logic             procEn_q, procEn_d;

  logic             startAccept;
  logic             shifting;
  logic             lastBit;
  logic             byteEnd;
  logic             outFree;
  logic             wrAccept;
  logic [7:0]       capNext;

  // Shared decode used by both the FSM and the datapath. A bit moves through
  // the chain only when the active write byte holds data and no completed
  // capture byte is parked waiting for the output register; otherwise the
  // chain simply holds. A byte ends either at its bit 7 or at the last chain
  // bit, so a partial final byte is closed early. The output register is free
  // when it is empty or is being handed over on this very edge, which is what
  // lets a new capture byte land in it back-to-back with a read handshake.
  always_comb begin
    startAccept = (state_q == IDLE) && start_i;
    shifting    = (state_q == SHIFT) && actValid_q && !capHeld_q;
    lastBit     = (bitCnt_q == LastBitIdx);
    byteEnd     = (bitIdx_q == 3'd7) || lastBit;
    outFree     = !outValid_q || bus.rd_ready;
    wrAccept    = (state_q == SHIFT) && !wrBufValid_q && bus.wr_valid;
    capNext           = capByte_q;
    capNext[bitIdx_q] = scan_out_i;
  end

  // Next-state logic. QUIESCE is a single stopped cycle that lets the
  // processor settle before the first shift. SHIFT leaves as soon as the last
  // chain bit moves; FLUSH then waits until nothing is parked and the final
  // byte is handed over. Start requests outside IDLE are ignored because only
  // the IDLE branch looks at start. The processor enable is registered so it
  // is glitch-free toward the microcontroller; it follows run_req only when
  // the coming state is IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = QUIESCE;
      QUIESCE: state_d = SHIFT;
      SHIFT:   if (shifting && lastBit) state_d = FLUSH;
      FLUSH:   if (!capHeld_q && outValid_q && bus.rd_ready) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    procEn_d = (state_d == IDLE) && run_req_i;
  end

  // Write side and bit counting. The host writes into a one-byte buffer that
  // only takes a byte while empty; the buffer is moved into the active shift
  // byte as soon as the active one is exhausted, including on the cycle its
  // last bit leaves, so shifting never pauses between bytes. Once the final
  // chain bit has moved nothing more is pulled in, so surplus write bits and
  // the unused top bits of a partial last byte never reach the chain.
  always_comb begin
    bitCnt_d     = bitCnt_q;
    bitIdx_d     = bitIdx_q;
    wrBuf_d      = wrBuf_q;
    wrBufValid_d = wrBufValid_q;
    actByte_d    = actByte_q;
    actValid_d   = actValid_q;

    if (wrAccept) begin
      wrBuf_d      = bus.wr_data;
      wrBufValid_d = 1'b1;
    end

    if (shifting) begin
      bitCnt_d = bitCnt_q + 1'b1;
      bitIdx_d = bitIdx_q + 3'd1;
    end

    if (shifting && byteEnd) begin
      actValid_d = 1'b0;
    end

    if ((state_q == SHIFT) && wrBufValid_q &&
        (!actValid_q || (shifting && byteEnd && !lastBit))) begin
      actByte_d    = wrBuf_q;
      actValid_d   = 1'b1;
      wrBufValid_d = 1'b0;
    end

    if (startAccept) begin
      bitCnt_d     = '0;
      bitIdx_d     = '0;
      wrBufValid_d = 1'b0;
      actValid_d   = 1'b0;
    end
  end

  // Read side. Each shift drops the tail bit into the capture byte at the
  // same bit position it had in the write stream. A finished capture byte
  // goes straight into the output register when that register is free;
  // otherwise it is parked and shifting stops until the host drains the
  // output register. Capture bits that are never written stay 0, which gives
  // zero-filled upper bits on a partial final byte.
  always_comb begin
    capByte_d  = capByte_q;
    capHeld_d  = capHeld_q;
    outData_d  = outData_q;
    outValid_d = outValid_q && !bus.rd_ready;

    if (capHeld_q && outFree) begin
      outData_d  = capByte_q;
      outValid_d = 1'b1;
      capHeld_d  = 1'b0;
      capByte_d  = '0;
    end else if (shifting) begin
      if (byteEnd) begin
        if (outFree) begin
          outData_d  = capNext;
          outValid_d = 1'b1;
          capByte_d  = '0;
        end else begin
          capByte_d  = capNext;
          capHeld_d  = 1'b1;
        end
      end else begin
        capByte_d = capNext;
      end
    end

    if (startAccept) begin
      capByte_d = '0;
      capHeld_d = 1'b0;
    end
  end

  // State and datapath registers. Reset aborts any operation in flight and
  // returns every buffer to empty without producing a done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      bitCnt_q     <= '0;
      bitIdx_q     <= '0;
      wrBuf_q      <= '0;
      wrBufValid_q <= 1'b0;
      actByte_q    <= '0;
      actValid_q   <= 1'b0;
      capByte_q    <= '0;
      capHeld_q    <= 1'b0;
      outData_q    <= '0;
      outValid_q   <= 1'b0;
      procEn_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      bitCnt_q     <= bitCnt_d;
      bitIdx_q     <= bitIdx_d;
      wrBuf_q      <= wrBuf_d;
      wrBufValid_q <= wrBufValid_d;
      actByte_q    <= actByte_d;
      actValid_q   <= actValid_d;
      capByte_q    <= capByte_d;
      capHeld_q    <= capHeld_d;
      outData_q    <= outData_d;
      outValid_q   <= outValid_d;
      procEn_q     <= procEn_d;
    end
  end

  // Outputs are decoded from registered state only, so they reach their
  // reset values as soon as reset is asserted. scan_in is forced low on any
  // cycle the chain is not shifting.
  assign proc_en_o     = procEn_q;
  assign scan_enable_o = shifting;
  assign scan_in_o     = shifting & actByte_q[bitIdx_q];
  assign busy_o        = (state_q != IDLE);
  assign done_o        = (state_q == DONE);
  assign bus.wr_ready  = (state_q == SHIFT) && !wrBufValid_q;
  assign bus.rd_valid  = outValid_q;
  assign bus.rd_data   = outData_q;

endmodule

// File: tb/tb_scan_chain_driver.sv
// ---------------------------------------------------------------------------
// tb_scan_chain_driver
//
// Directed bench for scan_chain_driver. A 16-bit instance runs against a
// loopback chain model preloaded with 0x5A, 0xC3; a 13-bit instance with the
// chain tail tied high covers the partial final byte.
// ---------------------------------------------------------------------------
module tb_scan_chain_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        runReq;
  logic        scanOut;
  logic        procEn, scanEn, scanIn, busy, done;

  logic        start13;
  logic        scanOut13;
  logic        procEn13, scanEn13, scanIn13, busy13, done13;

  logic [15:0] chain;
  logic        chainLoad;
  logic [15:0] chainPreload;

  int          testsRun = 0;
  int          testsFailed = 0;

  scan_chain_driver_if bus16();
  scan_chain_driver_if bus13();

  scan_chain_driver #(.CHAIN_LEN(16), .CNT_W(5)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_i       (start),
    .run_req_i     (runReq),
    .scan_out_i    (scanOut),
    .proc_en_o     (procEn),
    .scan_enable_o (scanEn),
    .scan_in_o     (scanIn),
    .busy_o        (busy),
    .done_o        (done),
    .bus           (bus16)
  );

  scan_chain_driver #(.CHAIN_LEN(13), .CNT_W(4)) dut13 (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_i       (start13),
    .run_req_i     (runReq),
    .scan_out_i    (scanOut13),
    .proc_en_o     (procEn13),
    .scan_enable_o (scanEn13),
    .scan_in_o     (scanIn13),
    .busy_o        (busy13),
    .done_o        (done13),
    .bus           (bus13)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Loopback model of the 16-bit scan chain: the tail bit is chain[0], and
  // every enabled shift pushes scan_in in at the head.
  assign scanOut   = chain[0];
  assign scanOut13 = 1'b1;

  always @(posedge clk) begin
    if (chainLoad) chain <= chainPreload;
    else if (scanEn) chain <= {scanIn, chain[15:1]};
  end

  // Runs one full pass on the 16-bit instance starting from IDLE at a
  // negedge. Inputs are driven and outputs sampled on negedges; a handshake
  // seen at a negedge completes on the following posedge.
  task automatic runPass16(input logic [7:0] w0, input logic [7:0] w1,
                           input int holdCycles, input bit midStart,
                           output logic [7:0] r0, output logic [7:0] r1,
                           output logic [15:0] sinBits, output int rdCnt,
                           output int enCnt, output int enRuns,
                           output int doneCnt, output int stableErr,
                           output int ruleErr, output bit timedOut);
    logic [7:0] wBytes [2];
    logic [7:0] rBytes [2];
    logic [7:0] heldData;
    int wrIdx = 0;
    int holdLeft = 0;
    bit prevEn = 0;
    bit holding = 0;
    bit holdArmed = 0;
    wBytes[0] = w0;
    wBytes[1] = w1;
    rBytes[0] = 8'h00;
    rBytes[1] = 8'h00;
    heldData  = 8'h00;
    sinBits   = 16'h0000;
    rdCnt = 0; enCnt = 0; enRuns = 0; doneCnt = 0;
    stableErr = 0; ruleErr = 0; timedOut = 1;
    start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (scanEn) begin
        if (enCnt < 16) sinBits[enCnt] = scanIn;
        enCnt++;
        if (!prevEn) enRuns++;
      end else if (scanIn !== 1'b0) begin
        ruleErr++;
      end
      prevEn = scanEn;
      if (busy && procEn !== 1'b0) ruleErr++;
      if (holding && (bus16.rd_valid !== 1'b1 || bus16.rd_data !== heldData)) stableErr++;
      if (done) begin
        doneCnt++;
        timedOut = 0;
        break;
      end
      start = (midStart && enCnt == 5) ? 1'b1 : 1'b0;
      bus16.wr_valid = (wrIdx < 2);
      if (wrIdx < 2) bus16.wr_data = wBytes[wrIdx];
      if (bus16.wr_valid && bus16.wr_ready) wrIdx++;
      if (!holdArmed && bus16.rd_valid && holdCycles > 0) begin
        holdArmed = 1;
        holdLeft  = holdCycles;
      end
      if (holdLeft > 0) begin
        bus16.rd_ready = 1'b0;
        holdLeft--;
      end else begin
        bus16.rd_ready = 1'b1;
      end
      holding  = bus16.rd_valid && !bus16.rd_ready;
      heldData = bus16.rd_data;
      if (bus16.rd_valid && bus16.rd_ready) begin
        if (rdCnt < 2) rBytes[rdCnt] = bus16.rd_data;
        rdCnt++;
      end
      @(posedge clk); @(negedge clk);
    end
    start = 1'b0;
    bus16.wr_valid = 1'b0;
    bus16.rd_ready = 1'b1;
    r0 = rBytes[0];
    r1 = rBytes[1];
  endtask

  // Reset values of every output, then proc_en tracking run_req from the
  // first edge after reset is released.
  task automatic test_reset();
    rst_n = 1'b0;
    runReq = 1'b1;
    chainPreload = 16'hC35A;
    chainLoad = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    testsRun++; if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    testsRun++; if (done !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    testsRun++; if (scanEn !== 1'b0 || scanIn !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_scan: got en=%b in=%b expected 0 0", scanEn, scanIn); end
    testsRun++; if (bus16.wr_ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_wr_ready: got %b expected 0", bus16.wr_ready); end
    testsRun++; if (bus16.rd_valid !== 1'b0 || bus16.rd_data !== 8'h00) begin testsFailed++; $display("[TB] FAIL reset_rd: got valid=%b data=%h expected 0 00", bus16.rd_valid, bus16.rd_data); end
    testsRun++; if (procEn !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_proc_en: got %b expected 0", procEn); end
    rst_n = 1'b1;
    chainLoad = 1'b0;
    @(posedge clk); @(negedge clk);
    testsRun++; if (procEn !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_proc_en_follow: got %b expected 1", procEn); end
    runReq = 1'b0;
    @(posedge clk); @(negedge clk);
    testsRun++; if (procEn !== 1'b0) begin testsFailed++; $display("[TB] FAIL idle_proc_en_low: got %b expected 0", procEn); end
  endtask

  // Write 0xA5, 0x3C against the preloaded chain with both streams ready.
  task automatic test_basic_shift();
    logic [7:0] r0, r1; logic [15:0] sinBits;
    int rdCnt, enCnt, enRuns, doneCnt, stableErr, ruleErr; bit timedOut;
    runPass16(8'hA5, 8'h3C, 0, 0, r0, r1, sinBits, rdCnt, enCnt, enRuns, doneCnt, stableErr, ruleErr, timedOut);
    testsRun++; if (timedOut !== 1'b0) begin testsFailed++; $display("[TB] FAIL basic_timeout: got no done expected done"); end
    testsRun++; if (sinBits !== 16'h3CA5) begin testsFailed++; $display("[TB] FAIL basic_scan_in: got %h expected 3ca5", sinBits); end
    testsRun++; if (enCnt != 16 || enRuns != 1) begin testsFailed++; $display("[TB] FAIL basic_enable: got %0d cycles in %0d runs expected 16 in 1", enCnt, enRuns); end
    testsRun++; if (rdCnt != 2 || r0 !== 8'h5A || r1 !== 8'hC3) begin testsFailed++; $display("[TB] FAIL basic_rd: got %0d bytes %h %h expected 2 bytes 5a c3", rdCnt, r0, r1); end
    testsRun++; if (ruleErr != 0) begin testsFailed++; $display("[TB] FAIL basic_rules: got %0d violations expected 0", ruleErr); end
    @(posedge clk); @(negedge clk);
    testsRun++; if (doneCnt != 1 || done !== 1'b0 || busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL basic_done_pulse: got count=%0d done=%b busy=%b expected 1 0 0", doneCnt, done, busy); end
  endtask

  // Second pass reads back what the first pass wrote.
  task automatic test_second_pass();
    logic [7:0] r0, r1; logic [15:0] sinBits;
    int rdCnt, enCnt, enRuns, doneCnt, stableErr, ruleErr; bit timedOut;
    runPass16(8'h12, 8'h34, 0, 0, r0, r1, sinBits, rdCnt, enCnt, enRuns, doneCnt, stableErr, ruleErr, timedOut);
    testsRun++; if (timedOut !== 1'b0) begin testsFailed++; $display("[TB] FAIL second_timeout: got no done expected done"); end
    testsRun++; if (rdCnt != 2 || r0 !== 8'hA5 || r1 !== 8'h3C) begin testsFailed++; $display("[TB] FAIL second_rd: got %0d bytes %h %h expected 2 bytes a5 3c", rdCnt, r0, r1); end
    testsRun++; if (sinBits !== 16'h3412 || enCnt != 16) begin testsFailed++; $display("[TB] FAIL second_scan_in: got %h over %0d expected 3412 over 16", sinBits, enCnt); end
    @(posedge clk); @(negedge clk);
  endtask

  // Hold rd_ready low for 20 cycles from the first read byte; the second
  // byte must park behind it without loss and the data must stay stable.
  task automatic test_rd_backpressure();
    logic [7:0] r0, r1; logic [15:0] sinBits;
    int rdCnt, enCnt, enRuns, doneCnt, stableErr, ruleErr; bit timedOut;
    runPass16(8'h00, 8'hFF, 20, 0, r0, r1, sinBits, rdCnt, enCnt, enRuns, doneCnt, stableErr, ruleErr, timedOut);
    testsRun++; if (timedOut !== 1'b0) begin testsFailed++; $display("[TB] FAIL hold_timeout: got no done expected done"); end
    testsRun++; if (rdCnt != 2 || r0 !== 8'h12 || r1 !== 8'h34) begin testsFailed++; $display("[TB] FAIL hold_rd: got %0d bytes %h %h expected 2 bytes 12 34", rdCnt, r0, r1); end
    testsRun++; if (stableErr != 0) begin testsFailed++; $display("[TB] FAIL hold_stable: got %0d unstable cycles expected 0", stableErr); end
    testsRun++; if (enCnt != 16 || doneCnt != 1) begin testsFailed++; $display("[TB] FAIL hold_count: got %0d shifts %0d done expected 16 1", enCnt, doneCnt); end
    @(posedge clk); @(negedge clk);
  endtask

  // proc_en drops for the whole operation and returns in IDLE; a start
  // pulse during SHIFT is ignored.
  task automatic test_proc_en();
    logic [7:0] r0, r1; logic [15:0] sinBits;
    int rdCnt, enCnt, enRuns, doneCnt, stableErr, ruleErr; bit timedOut;
    runReq = 1'b1;
    @(posedge clk); @(negedge clk);
    testsRun++; if (procEn !== 1'b1) begin testsFailed++; $display("[TB] FAIL proc_en_idle: got %b expected 1", procEn); end
    runPass16(8'h55, 8'hAA, 0, 1, r0, r1, sinBits, rdCnt, enCnt, enRuns, doneCnt, stableErr, ruleErr, timedOut);
    testsRun++; if (timedOut !== 1'b0) begin testsFailed++; $display("[TB] FAIL proc_timeout: got no done expected done"); end
    testsRun++; if (ruleErr != 0) begin testsFailed++; $display("[TB] FAIL proc_en_busy: got %0d violations expected 0", ruleErr); end
    testsRun++; if (enCnt != 16 || enRuns != 1 || doneCnt != 1) begin testsFailed++; $display("[TB] FAIL proc_mid_start: got %0d shifts %0d runs %0d done expected 16 1 1", enCnt, enRuns, doneCnt); end
    testsRun++; if (r0 !== 8'h00 || r1 !== 8'hFF) begin testsFailed++; $display("[TB] FAIL proc_rd: got %h %h expected 00 ff", r0, r1); end
    @(posedge clk); @(negedge clk);
    testsRun++; if (procEn !== 1'b1 || busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL proc_en_return: got proc_en=%b busy=%b expected 1 0", procEn, busy); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    testsRun++; if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL proc_stray_start: got busy=%b expected 0", busy); end
  endtask

  // Reset in the middle of SHIFT, then a clean full pass.
  task automatic test_reset_mid_shift();
    logic [7:0] r0, r1; logic [15:0] sinBits;
    int rdCnt, enCnt, enRuns, doneCnt, stableErr, ruleErr; bit timedOut;
    int cnt = 0;
    bit doneSeen = 0;
    start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    bus16.wr_valid = 1'b1;
    bus16.wr_data  = 8'hFF;
    for (int cyc = 0; cyc < 50; cyc++) begin
      if (scanEn) cnt++;
      if (cnt == 7) break;
      @(posedge clk); @(negedge clk);
    end
    testsRun++; if (cnt != 7) begin testsFailed++; $display("[TB] FAIL abort_reach_k7: got %0d shifts expected 7", cnt); end
    @(posedge clk); @(negedge clk);
    rst_n = 1'b0;
    #1;
    testsRun++; if (busy !== 1'b0 || done !== 1'b0 || procEn !== 1'b0) begin testsFailed++; $display("[TB] FAIL abort_ctrl: got busy=%b done=%b proc_en=%b expected 0 0 0", busy, done, procEn); end
    testsRun++; if (scanEn !== 1'b0 || scanIn !== 1'b0 || bus16.wr_ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL abort_scan: got en=%b in=%b wr_ready=%b expected 0 0 0", scanEn, scanIn, bus16.wr_ready); end
    testsRun++; if (bus16.rd_valid !== 1'b0 || bus16.rd_data !== 8'h00) begin testsFailed++; $display("[TB] FAIL abort_rd: got valid=%b data=%h expected 0 00", bus16.rd_valid, bus16.rd_data); end
    bus16.wr_valid = 1'b0;
    chainPreload = 16'hC35A;
    chainLoad = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (done) doneSeen = 1;
      @(posedge clk); @(negedge clk);
    end
    chainLoad = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    if (done) doneSeen = 1;
    testsRun++; if (doneSeen) begin testsFailed++; $display("[TB] FAIL abort_no_done: got done pulse expected none"); end
    testsRun++; if (procEn !== 1'b1) begin testsFailed++; $display("[TB] FAIL abort_proc_en_follow: got %b expected 1", procEn); end
    runPass16(8'hA5, 8'h3C, 0, 0, r0, r1, sinBits, rdCnt, enCnt, enRuns, doneCnt, stableErr, ruleErr, timedOut);
    testsRun++; if (timedOut !== 1'b0 || doneCnt != 1) begin testsFailed++; $display("[TB] FAIL abort_rerun_done: got %0d done expected 1", doneCnt); end
    testsRun++; if (enCnt != 16 || sinBits !== 16'h3CA5) begin testsFailed++; $display("[TB] FAIL abort_rerun_shift: got %0d shifts data %h expected 16 3ca5", enCnt, sinBits); end
    testsRun++; if (r0 !== 8'h5A || r1 !== 8'hC3) begin testsFailed++; $display("[TB] FAIL abort_rerun_rd: got %h %h expected 5a c3", r0, r1); end
    @(posedge clk); @(negedge clk);
    runReq = 1'b0;
  endtask

  // 13-bit chain with the tail tied high: 13 shifts, second read byte 0x1F.
  task automatic test_short_chain();
    logic [7:0] wb [2];
    logic [7:0] rb [2];
    logic [7:0] second;
    int wrIdx = 0;
    int rdIdx = 0;
    int enCnt = 0;
    int doneCnt = 0;
    wb[0] = 8'hFF; wb[1] = 8'hFF;
    rb[0] = 8'h00; rb[1] = 8'h00;
    start13 = 1'b1;
    @(posedge clk); @(negedge clk);
    start13 = 1'b0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      if (scanEn13) enCnt++;
      if (done13) begin
        doneCnt++;
        break;
      end
      bus13.wr_valid = (wrIdx < 2);
      if (wrIdx < 2) bus13.wr_data = wb[wrIdx];
      if (bus13.wr_valid && bus13.wr_ready) wrIdx++;
      bus13.rd_ready = 1'b1;
      if (bus13.rd_valid) begin
        if (rdIdx < 2) rb[rdIdx] = bus13.rd_data;
        rdIdx++;
      end
      @(posedge clk); @(negedge clk);
    end
    bus13.wr_valid = 1'b0;
    second = rb[1];
    testsRun++; if (doneCnt != 1) begin testsFailed++; $display("[TB] FAIL short_done: got %0d expected 1", doneCnt); end
    testsRun++; if (enCnt != 13) begin testsFailed++; $display("[TB] FAIL short_shift_count: got %0d expected 13", enCnt); end
    testsRun++; if (rdIdx != 2 || rb[0] !== 8'hFF || rb[1] !== 8'h1F) begin testsFailed++; $display("[TB] FAIL short_rd: got %0d bytes %h %h expected 2 bytes ff 1f", rdIdx, rb[0], rb[1]); end
    testsRun++; if (second[7:5] !== 3'b000) begin testsFailed++; $display("[TB] FAIL short_msb_zero: got %b expected 000", second[7:5]); end
  endtask

  // Test sequence followed by the summary line.
  initial begin
    start = 1'b0;
    start13 = 1'b0;
    runReq = 1'b0;
    chainLoad = 1'b0;
    chainPreload = 16'h0000;
    bus16.wr_valid = 1'b0; bus16.wr_data = 8'h00; bus16.rd_ready = 1'b1;
    bus13.wr_valid = 1'b0; bus13.wr_data = 8'h00; bus13.rd_ready = 1'b1;
    test_reset();
    test_basic_shift();
    test_second_pass();
    test_rd_backpressure();
    test_proc_en();
    test_reset_mid_shift();
    test_short_chain();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/scan_chain_driver.md
SCAN_CHAIN_DRIVER -- requirements
Module: scan_chain_driver

Interface
REQ-001 Parameter CHAIN_LEN, default 64: scan chain length in bits, legal range 1..4096.
REQ-002 Parameter CNT_W, default 13: bit counter width, SHALL satisfy 2^CNT_W > CHAIN_LEN.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  one-cycle request to begin a full-chain shift; sampled only in IDLE.
REQ-006 run_req  input  1  software request for the processor to run when no shift is active.
REQ-007 wr_valid, wr_data[7:0] / wr_ready  input, input / output  1, 8 / 1  byte stream of bits to shift into the chain.
REQ-008 rd_valid, rd_data[7:0] / rd_ready  output, output / input  1, 8 / 1  byte stream of bits captured from the chain.
REQ-009 proc_en  output  1  processor enable to the microcontroller.
REQ-010 scan_enable  output  1  scan shift enable to the microcontroller.
REQ-011 scan_in  output  1  serial data into the chain.
REQ-012 scan_out  input  1  serial data from the chain tail.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle pulse when an operation completes.

Function
REQ-015 States SHALL be IDLE, QUIESCE, SHIFT, FLUSH, DONE.
REQ-016 In IDLE, start=1 SHALL move to QUIESCE, clear the bit counter, and clear the capture byte.
REQ-017 QUIESCE SHALL last exactly one cycle with proc_en=0 and scan_enable=0, then move to SHIFT.
REQ-018 proc_en SHALL equal run_req in IDLE, and SHALL be 0 in QUIESCE, SHIFT, FLUSH, and DONE.
REQ-019 Bit k of the stream (k = 0..CHAIN_LEN-1) SHALL be bit k%8 of write byte k/8 (LSB first).
REQ-020 A write byte SHALL be accepted (wr_valid and wr_ready) only when the driver's input byte buffer is empty; wr_ready SHALL be 0 outside SHIFT.
REQ-021 In SHIFT, scan_enable SHALL be 1 only in cycles where a write bit is buffered and the capture byte is not held awaiting rd handshake; otherwise scan_enable=0 and the chain SHALL hold.
REQ-022 On each cycle with scan_enable=1: scan_in SHALL equal stream bit k; scan_out SHALL be sampled into capture bit k%8; k SHALL increment by one.
REQ-023 When capture bit 7 is written, or when k reaches CHAIN_LEN, the capture byte SHALL be presented with rd_valid=1 and held stable until rd_ready=1.
REQ-024 Unused MSBs of the final partial byte, in both directions, SHALL be ignored on write and driven 0 on read.
REQ-025 Write bits beyond CHAIN_LEN SHALL be discarded; the final write byte's unused bits SHALL not be shifted.
REQ-026 When k reaches CHAIN_LEN, the state SHALL move to FLUSH and scan_enable SHALL be 0.
REQ-027 FLUSH SHALL wait for the last rd handshake, then move to DONE.
REQ-028 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-029 start asserted while busy SHALL be ignored.
REQ-030 Simultaneous rd handshake and new capture completion SHALL not lose or duplicate a byte: a one-byte output register plus the active capture byte SHALL give back-to-back throughput of one bit per clock when both streams are always ready.
REQ-031 scan_in SHALL be 0 whenever scan_enable=0.

Reset
REQ-032 When rst=0, asynchronously: state=IDLE, counter=0, buffers empty, proc_en=0, scan_enable=0, scan_in=0, wr_ready=0, rd_valid=0, rd_data=0, busy=0, done=0.
REQ-033 Reset asserted mid-SHIFT SHALL abort the operation with no done pulse; partial chain contents are then undefined.
REQ-034 After reset deassertion, proc_en SHALL follow run_req from the first clock edge.

Verification
REQ-035 CHAIN_LEN=16 with streams always ready; write 0xA5, 0x3C -> scan_in sequence 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0; exactly 16 scan_enable cycles, contiguous; done pulses once.
REQ-036 Loopback (scan_out tied to scan_in delayed 16 cycles via a model chain preloaded with 0x5A, 0xC3) -> rd bytes 0x5A then 0xC3; a second pass returns 0xA5, 0x3C.
REQ-037 CHAIN_LEN=13, write 0xFF, 0xFF -> 13 shift cycles; second rd byte has bits 7:5 equal to 0.
REQ-038 Hold rd_ready=0 for 20 cycles after the first byte -> scan_enable stays 0, rd_data stays stable, no bits are lost; the total shift count is still CHAIN_LEN.
REQ-039 run_req=1, then pulse start -> proc_en falls on the QUIESCE cycle, stays 0 through DONE, and returns to 1 in IDLE; a start pulse mid-SHIFT has no effect.
REQ-040 Assert rst mid-SHIFT at k=7 -> all outputs reach their reset values immediately; there is no done pulse; a new start then runs a full CHAIN_LEN shift.
